// File: rtl/firebird7_in_gate1_ijtag_scan_host.sv
// IJTAG scan host for the gate1 network: one capture-shift-update sequence per request.
// Optional select-only capture slot under FIREBIRD7_IJTAG_HOST_SKIP_CAPTURE_EN.
module firebird7_in_gate1_ijtag_scan_host #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [MAX_LEN-1:0] req_data,
`ifdef FIREBIRD7_IJTAG_HOST_SKIP_CAPTURE_EN
  input  logic               req_no_capture,
`endif
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_UPDATE  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] bit_q, bit_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               req_ready_q, req_ready_d;
  logic               no_cap_q, no_cap_d;

  logic sel_q, sel_d, ce_q, ce_d, se_q, se_d, ue_q, ue_d, si_q, si_d;

  // Sequencer: state, shift position (one-hot bit_q) and captured so bits.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    bit_d       = bit_q;
    cap_d       = cap_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    no_cap_d    = no_cap_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d = ST_CAPTURE;
          len_d   = (req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len;
          data_d  = req_data;
          cap_d   = '0;
          bit_d   = MAX_LEN'(1);
          cnt_d   = '0;
`ifdef FIREBIRD7_IJTAG_HOST_SKIP_CAPTURE_EN
          no_cap_d = req_no_capture;
`else
          no_cap_d = 1'b0;
`endif
        end
      end
      ST_CAPTURE: state_d = (len_q == '0) ? ST_UPDATE : ST_SHIFT;
      ST_SHIFT: begin
        cap_d = cap_q | ({MAX_LEN{ijtag_so}} & bit_q);
        bit_d = bit_q << 1;
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q + LEN_W'(1) == len_q) state_d = ST_UPDATE;
      end
      ST_UPDATE: state_d = ST_DONE;
      ST_DONE: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = cap_q;
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      bit_q       <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      no_cap_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      bit_q       <= bit_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      no_cap_q    <= no_cap_d;
    end
  end

  // Network drivers follow the state registered at the preceding posedge.
  always_comb begin
    sel_d = 1'b0;
    ce_d  = 1'b0;
    se_d  = 1'b0;
    ue_d  = 1'b0;
    si_d  = 1'b0;
    case (state_q)
      ST_CAPTURE: begin
        sel_d = 1'b1;
        ce_d  = ~no_cap_q;
      end
      ST_SHIFT: begin
        sel_d = 1'b1;
        se_d  = 1'b1;
        si_d  = |(data_q & bit_q);
      end
      ST_UPDATE: begin
        sel_d = 1'b1;
        ue_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Negedge flops keep network signals stable across instrument posedge/negedge sampling.
  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sel_q <= 1'b0;
      ce_q  <= 1'b0;
      se_q  <= 1'b0;
      ue_q  <= 1'b0;
      si_q  <= 1'b0;
    end else begin
      sel_q <= sel_d;
      ce_q  <= ce_d;
      se_q  <= se_d;
      ue_q  <= ue_d;
      si_q  <= si_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign ijtag_sel = sel_q;
  assign ijtag_ce  = ce_q;
  assign ijtag_se  = se_q;
  assign ijtag_ue  = ue_q;
  assign ijtag_si  = si_q;

endmodule

// File: tb/tb_firebird7_in_gate1_ijtag_scan_host.sv
// Scoreboard bench for the gate1 IJTAG scan host with loopback, SIB and TDR network models.
module tb_firebird7_in_gate1_ijtag_scan_host;

  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned LEN_W   = 7;

  logic               ijtag_tck = 1'b0;
  logic               ijtag_reset = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [LEN_W-1:0]   req_len = '0;
  logic [MAX_LEN-1:0] req_data = '0;
  logic               req_no_capture = 1'b0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, ijtag_so;

  firebird7_in_gate1_ijtag_scan_host #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .ijtag_tck(ijtag_tck), .ijtag_reset(ijtag_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len), .req_data(req_data),
`ifdef FIREBIRD7_IJTAG_HOST_SKIP_CAPTURE_EN
    .req_no_capture(req_no_capture),
`endif
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ijtag_sel(ijtag_sel), .ijtag_ce(ijtag_ce), .ijtag_se(ijtag_se), .ijtag_ue(ijtag_ue),
    .ijtag_si(ijtag_si), .ijtag_so(ijtag_so)
  );

  initial forever #5 ijtag_tck = ~ijtag_tck;

  int cyc = 0;
  always @(posedge ijtag_tck) cyc <= cyc + 1;

  // Network models: 0 loopback flop, 1 single SIB, 2 four-bit TDR capturing 4'h9.
  int   mode = 0;
  logic lb_q = 1'b0;
  logic sib_sr = 1'b0, sib_st = 1'b0;
  logic [3:0] tdr = 4'h0;
  always @(posedge ijtag_tck) begin
    lb_q <= ijtag_si;
    if (ijtag_sel && ijtag_ce) begin
      sib_sr <= sib_st;
      tdr    <= 4'h9;
    end else if (ijtag_sel && ijtag_se) begin
      sib_sr <= ijtag_si;
      tdr    <= {ijtag_si, tdr[3:1]};
    end
  end
  always @(negedge ijtag_tck) if (ijtag_sel && ijtag_ue) sib_st <= sib_sr;
  assign ijtag_so = (mode == 1) ? sib_sr : (mode == 2) ? tdr[0] : lb_q;

  typedef struct {
    logic [MAX_LEN-1:0] data;
    int n_sel, n_ce, n_se, n_ue, cyc;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int last_rsp_cyc = 0;
  int last_acc_cyc = 0;

  task automatic chk(input string name, input logic [MAX_LEN-1:0] act, input logic [MAX_LEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: per-sequence signal period counts, invariants, response compare.
  int c_sel = 0, c_ce = 0, c_se = 0, c_ue = 0;
  initial forever begin
    @(posedge ijtag_tck);
    #1;
    if (!ijtag_reset) begin
      c_sel = 0; c_ce = 0; c_se = 0; c_ue = 0;
    end else begin
      chk("invariant", 64'(((32'(ijtag_ce) + 32'(ijtag_se) + 32'(ijtag_ue)) > 1) ||
                           ((ijtag_ce || ijtag_se || ijtag_ue) && !ijtag_sel) ||
                           (ijtag_si && !ijtag_se)), 64'd0);
      c_sel += 32'(ijtag_sel); c_ce += 32'(ijtag_ce);
      c_se  += 32'(ijtag_se);  c_ue += 32'(ijtag_ue);
      if (rsp_valid) begin
        last_rsp_cyc = cyc;
        if (q.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
          chk("sel_periods", 64'(c_sel), 64'(e.n_sel));
          chk("ce_periods", 64'(c_ce), 64'(e.n_ce));
          chk("se_periods", 64'(c_se), 64'(e.n_se));
          chk("ue_periods", 64'(c_ue), 64'(e.n_ue));
          chk("ready_on_rsp", 64'(req_ready), 64'd1);
        end
        c_sel = 0; c_ce = 0; c_se = 0; c_ue = 0;
      end else if (q.size() != 0 && cyc > q[0].cyc) begin
        chk("rsp_timeout", 64'(cyc), 64'(q[0].cyc));
        void'(q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic issue(input int len_req, input logic [MAX_LEN-1:0] data,
                       input logic [MAX_LEN-1:0] exp_data, input bit no_cap, input bit push);
    int n;
    bit ok;
    exp_t e;
    n = (len_req > int'(MAX_LEN)) ? int'(MAX_LEN) : len_req;
    req_len = LEN_W'(len_req);
    req_data = data;
    req_no_capture = no_cap;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge ijtag_tck);
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    last_acc_cyc = cyc + 1;
    e.data = exp_data; e.n_sel = n + 2; e.n_ce = no_cap ? 0 : 1;
    e.n_se = n; e.n_ue = 1; e.cyc = cyc + 1 + n + 3;
    if (push) q.push_back(e);
    @(posedge ijtag_tck);
    @(negedge ijtag_tck);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge ijtag_tck);
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    repeat (3) @(negedge ijtag_tck);
  endtask

  initial begin
    // Power-on reset.
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_outs", 64'({ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, rsp_valid}), 64'd0);
    repeat (2) @(negedge ijtag_tck);
    ijtag_reset = 1'b1;
    @(posedge ijtag_tck); #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    @(negedge ijtag_tck);

    // Single SIB: open, then close.
    mode = 1;
    issue(1, 64'd1, 64'd0, 1'b0, 1'b1);
    drain();
    chk("sib_open", 64'(sib_st), 64'd1);
    issue(1, 64'd0, 64'd1, 1'b0, 1'b1);
    drain();
    chk("sib_closed", 64'(sib_st), 64'd0);

    // Loopback through one posedge flop: bit k returns data[k-1].
    mode = 0;
    issue(8, 64'hA5, 64'h4A, 1'b0, 1'b1);
    drain();

    // Zero length.
    issue(0, 64'hFF, 64'd0, 1'b0, 1'b1);
    drain();

    // Clamp to MAX_LEN.
    issue(int'(MAX_LEN) + 5, {MAX_LEN{1'b1}}, {{(MAX_LEN-1){1'b1}}, 1'b0}, 1'b0, 1'b1);
    drain();

    // Back-to-back: second accepted on the rsp_valid cycle.
    issue(3, 64'h5, 64'h2, 1'b0, 1'b1);
    issue(2, 64'h3, 64'h2, 1'b0, 1'b1);
    chk("b2b_accept", 64'(last_acc_cyc), 64'(last_rsp_cyc + 1));
    drain();

    // Request during a busy sequence is ignored.
    issue(4, 64'h0F, 64'h0E, 1'b0, 1'b1);
    req_valid = 1'b1; req_len = LEN_W'(2); req_data = '1;
    repeat (3) @(negedge ijtag_tck);
    req_valid = 1'b0;
    drain();
    repeat (10) @(negedge ijtag_tck);

    // Reset mid-SHIFT aborts the sequence.
    issue(8, 64'hA5, 64'd0, 1'b0, 1'b0);
    repeat (4) @(posedge ijtag_tck);
    #2 ijtag_reset = 1'b0;
    #1;
    chk("abort_outs", 64'({ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, rsp_valid}), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd0);
    chk("abort_rsp_data", rsp_data, 64'd0);
    @(negedge ijtag_tck);
    ijtag_reset = 1'b1;
    @(posedge ijtag_tck); #1;
    chk("abort_ready_after", 64'(req_ready), 64'd1);
    chk("abort_rsp_data_after", rsp_data, 64'd0);
    repeat (15) @(negedge ijtag_tck);

`ifdef FIREBIRD7_IJTAG_HOST_SKIP_CAPTURE_EN
    // Select-only capture returns the previously shifted-in TDR contents.
    mode = 2;
    issue(4, 64'h6, 64'h9, 1'b0, 1'b1);
    drain();
    issue(4, 64'h3, 64'h6, 1'b1, 1'b1);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/firebird7_in_gate1_ijtag_scan_host.md
Name: firebird7_in_gate1_ijtag_scan_host

Overview:
- IJTAG network driver: the initiator side of the SIB and TDR instrument segments on the gate1 IJTAG network.
- Accepts a scan request over a valid/ready handshake, then generates one complete capture-shift-update sequence on the ijtag_sel/ce/se/ue/si signals.
- Samples the returned ijtag_so stream and hands back the captured bits.
- Sits between an in-system BIST sequencer and the root of the gate1 IJTAG chain, in the ijtag_tck domain.

Parameters:
- MAX_LEN, 64: maximum scan length in bits; width of req_data and rsp_data.
- LEN_W, $clog2(MAX_LEN+1): width of req_len.

Ports:
- ijtag_tck  in  1  network clock; FSM on posedge, network drivers on negedge.
- ijtag_reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  scan request valid.
- req_ready  out  1  host idle, can accept a request.
- req_len  in  LEN_W  number of shift cycles, 0..MAX_LEN.
- req_data  in  MAX_LEN  shift-in data, bit k driven on shift cycle k (LSB first).
- rsp_valid  out  1  one-cycle pulse, rsp_data valid.
- rsp_data  out  MAX_LEN  captured so bits, bit k sampled on shift cycle k.
- ijtag_sel  out  1  segment select to network root.
- ijtag_ce  out  1  capture enable.
- ijtag_se  out  1  shift enable.
- ijtag_ue  out  1  update enable.
- ijtag_si  out  1  scan data toward network.
- ijtag_so  in  1  scan data returning from network.

Behaviour:
- Reset (async, ijtag_reset=0):
  - All outputs 0 immediately, except req_ready, which is 0 during reset and 1 on the first posedge after release.
  - FSM goes to IDLE; rsp_data cleared.
  - Reset mid-sequence aborts it: no rsp_valid, and no ue pulse is emitted.
- Request acceptance:
  - Request accepted at posedge P0 with req_valid & req_ready.
  - req_data and len are latched at P0. len = min(req_len, MAX_LEN); values > MAX_LEN are clamped.
  - req_ready drops to 0 at P0 and stays 0 until the sequence ends.
- FSM states, registered on posedge: IDLE -> CAPTURE -> SHIFT -> UPDATE -> DONE -> IDLE.
  - SHIFT is skipped when len=0.
- Network drivers are negedge flops, so values are stable around each posedge and each negedge that instruments sample.
- Timeline for len=N (Nk = negedge following Pk):
  - N0: sel=1, ce=1. Instruments capture at P1.
  - N1..NN: ce=0, se=1, si=data[k] at N(k+1). Instruments shift at P(k+2).
  - Host samples ijtag_so at the same posedge P(k+2) into rsp_data[k].
  - N(N+1): se=0, ue=1, sel=1, si=0.
  - N(N+2): ue=0, sel=0.
  - ue=1 and sel=1 are therefore held across exactly one full period, so downstream negedge update latches see ue&sel=1 at N(N+2).
  - P(N+3): rsp_valid=1 for one posedge cycle. req_ready=1 from the same edge.
- Invariants:
  - ce, se and ue are mutually exclusive.
  - ce, se and ue are never 1 while sel=0.
  - si=0 whenever se=0.
  - Total sel-high time is N+2 periods.
- Data rules:
  - rsp_data bits >= len are 0.
  - rsp_data holds its value until the next accepted request's DONE, or until reset.
- Sequencing: a new req_valid during a busy sequence is ignored (no queueing). It may be accepted on the rsp_valid cycle, since req_ready=1 then.

Optional Feature:
- Macro: FIREBIRD7_IJTAG_HOST_SKIP_CAPTURE_EN.
- When defined:
  - Adds input port req_no_capture (1 bit), latched at acceptance.
  - When it is 1, the CAPTURE slot keeps sel=1 but drives ce=0 (a select-only cycle), so instrument registers shift their current contents.
  - Timing is otherwise identical.
- When undefined: port absent; ce is always pulsed.

Test Plan:
- Reset: ijtag_reset=0 mid-SHIFT at len=8 -> sel/ce/se/ue/si=0 asynchronously, no rsp_valid, req_ready=1 at first posedge after release, rsp_data=0.
- Single SIB loop (this host driving one gate1 SIB; SIB from_so tied to its own so):
  - Scan 1: len=1, data=1 -> rsp_data[0]=0 (cleared by capture). The SIB opens after update: to_sel=1 two negedges later.
  - Scan 2: len=1, data=0 -> to_sel returns to 0 after update.
- Loopback (ijtag_so<=si via a posedge flop): len=8, data=0xA5 -> rsp_data=0xA5 shifted by one bit position per the one-flop delay, bits >= 8 are 0; se high exactly 8 posedges, ue high exactly 1 period.
- Zero length: len=0 -> ce period followed directly by ue period; sel high 2 periods; rsp_valid at P3; rsp_data=0.
- Clamp and back-to-back:
  - req_len=MAX_LEN+5 -> exactly MAX_LEN shift cycles.
  - req_valid held high -> second request accepted on the rsp_valid cycle.
  - req_valid asserted mid-sequence -> ignored (req_ready=0), no extra sequence.
- With FIREBIRD7_IJTAG_HOST_SKIP_CAPTURE_EN: req_no_capture=1, len=4 -> ce never 1, sel high 6 periods, rsp_data returns the previously shifted-in instrument contents.
